// File: rtl/uart_rx_16x.sv
// uart_rx_16x: UART receiver clocked by the 16x baud clock.
// Start/data/parity/stop deserializer feeding a one-entry holding register
// with parity, framing and sticky overrun flags, popped by a one-cycle read.
module uart_rx_16x #(
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk16x,
    input  logic                 reset_n,
    input  logic                 rx_in,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q;
    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 commit;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 par_bad;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM and shift-register state.
    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
        end
    end

    // Next-state: mid-bit start check at cnt=7, then one sample per 16 ticks
    // at cnt=15 (the 4-bit counter wraps to 0 for the next bit).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 4'd1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (!sync2_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == 4'd7) begin
                    if (sync2_q) begin
                        state_d = S_IDLE;      // glitch, not a start bit
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = 4'd0;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == 4'd15) begin
                    shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT)
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    else
                        bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (cnt_q == 4'd15) begin
                    par_d   = sync2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == 4'd15) begin
                    commit  = 1'b1;
                    // A low stop may be a break; wait for the line to recover.
                    state_d = sync2_q ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = 4'd0;
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign par_bad = PARITY_EN && (par_q != ((^shreg_q) ^ PARITY_ODD));

    // Holding register: a commit beats a same-edge read; a commit while
    // still full drops the frame and raises the sticky overrun flag.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (commit) begin
            if (!ready_q || rx_read) begin
                data_d  = shreg_q;
                ready_d = 1'b1;
                perr_d  = par_bad;
                ferr_d  = !sync2_q;
                if (rx_read) ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_read) begin
            ready_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            ready_q <= ready_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_ready     = ready_q;
    assign parity_error = perr_q;
    assign frame_error  = ferr_q;
    assign overrun      = ovr_q;

endmodule
